datapath_responder: RTL and testbench



---
 rtl/datapath_responder_if.sv | 37 +++
 rtl/datapath_responder.sv | 207 ++++++++++++++++++++
 tb/tb_datapath_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : datapath_responder_if
// Description : Command handshake and VGA plot bundle for datapath_responder.
//               The master side is the initiator plus the plot sink; the slave
//               side is the responder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface datapath_responder_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int X_COORD_WIDTH     = 8,
    parameter int Y_COORD_WIDTH     = 7,
    parameter int COLOUR_WIDTH      = 3
) ();
    logic                         start;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         finished;
    logic [DATA_WIDTH-1:0]        result;
    logic                         error;
    logic                         vga_ready;
    logic [X_COORD_WIDTH-1:0]     vga_x;
    logic [Y_COORD_WIDTH-1:0]     vga_y;
    logic [COLOUR_WIDTH-1:0]      vga_colour;
    logic                         vga_plot;

    modport master (
        output start, instruction, vga_ready,
        input  finished, result, error, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, instruction, vga_ready,
        output finished, result, error, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/datapath_responder.sv
`default_nettype none
// ============================================================================
// Module      : datapath_responder
// Description : Executes one instruction (NOP / MEMREAD / MEMWRITE / DRAW) per
//               rising edge of start. Owns the state RAM and drives the VGA
//               plot port. finished is high whenever no command is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_responder #(
    parameter int OPCODE_WIDTH      = 3,
    parameter int MEM_ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH        = 16,
    parameter int X_COORD_WIDTH     = 8,
    parameter int Y_COORD_WIDTH     = 7,
    parameter int COLOUR_WIDTH      = 3,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  wire logic           clock,
    input  wire logic           reset,
    datapath_responder_if.slave bus
);
    localparam int MEM_FIELD_W  = OPCODE_WIDTH + MEM_ADDR_WIDTH + DATA_WIDTH;
    localparam int DRAW_FIELD_W = OPCODE_WIDTH + X_COORD_WIDTH + Y_COORD_WIDTH + COLOUR_WIDTH + 1;
    localparam int LATCH_W      = (MEM_FIELD_W > DRAW_FIELD_W) ? MEM_FIELD_W : DRAW_FIELD_W;
    localparam int DEPTH        = 1 << MEM_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_DECODE      = 3'd1;
    localparam logic [2:0] S_MEM_RD      = 3'd2;
    localparam logic [2:0] S_MEM_RD_DATA = 3'd3;
    localparam logic [2:0] S_MEM_WR      = 3'd4;
    localparam logic [2:0] S_DRAW        = 3'd5;
    localparam logic [2:0] S_DRAW_END    = 3'd6;
    localparam logic [2:0] S_DONE        = 3'd7;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_MEMREAD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MEMWRITE = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAW     = OPCODE_WIDTH'(3);

    logic [2:0]                state_q, state_d;
    logic                      start_q;
    logic [LATCH_W-1:0]        instr_q, instr_d;
    logic                      finished_q, finished_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic                      error_q, error_d;
    logic [X_COORD_WIDTH-1:0]  vga_x_q, vga_x_d;
    logic [Y_COORD_WIDTH-1:0]  vga_y_q, vga_y_d;
    logic [COLOUR_WIDTH-1:0]   vga_colour_q, vga_colour_d;
    logic                      vga_plot_q, vga_plot_d;
    logic                      ram_we;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]     mem_rdata_q;

    // Field views of the latched instruction; MEM and DRAW layouts overlap.
    logic [OPCODE_WIDTH-1:0]   w_op;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [X_COORD_WIDTH-1:0]  w_x;
    logic [Y_COORD_WIDTH-1:0]  w_y;
    logic [COLOUR_WIDTH-1:0]   w_colour;
    logic                      w_plot_en;
    logic                      w_accept;

    assign w_op      = instr_q[OPCODE_WIDTH-1:0];
    assign w_addr    = instr_q[OPCODE_WIDTH +: MEM_ADDR_WIDTH];
    assign w_data    = instr_q[OPCODE_WIDTH + MEM_ADDR_WIDTH +: DATA_WIDTH];
    assign w_x       = instr_q[OPCODE_WIDTH +: X_COORD_WIDTH];
    assign w_y       = instr_q[OPCODE_WIDTH + X_COORD_WIDTH +: Y_COORD_WIDTH];
    assign w_colour  = instr_q[OPCODE_WIDTH + X_COORD_WIDTH + Y_COORD_WIDTH +: COLOUR_WIDTH];
    assign w_plot_en = instr_q[DRAW_FIELD_W-1];

    // Only a rising edge of start in IDLE begins a command, so a held start
    // cannot retrigger once the command has completed.
    assign w_accept  = (state_q == S_IDLE) && bus.start && !start_q;

    // Instruction bits above the widest layout carry no meaning.
    generate
        if (INSTRUCTION_WIDTH > LATCH_W) begin : g_unused_upper
            logic w_unused_upper;
            assign w_unused_upper = ^bus.instruction[INSTRUCTION_WIDTH-1:LATCH_W];
        end
    endgenerate

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            instr_q      <= '0;
            finished_q   <= 1'b1;
            result_q     <= '0;
            error_q      <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.start;
            instr_q      <= instr_d;
            finished_q   <= finished_d;
            result_q     <= result_d;
            error_q      <= error_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (w_accept) state_d = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_MEMREAD:  state_d = S_MEM_RD;
                    OP_MEMWRITE: state_d = S_MEM_WR;
                    OP_DRAW:     state_d = S_DRAW;
                    default:     state_d = S_DONE;
                endcase
            end
            S_MEM_RD:      state_d = S_MEM_RD_DATA;
            S_MEM_RD_DATA: state_d = S_IDLE;
            S_MEM_WR:      state_d = S_IDLE;
            S_DRAW:        if (bus.vga_ready) state_d = S_DRAW_END;
            S_DRAW_END:    state_d = S_IDLE;
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; everything holds unless a state acts.
    always_comb begin
        instr_d      = instr_q;
        finished_d   = finished_q;
        result_d     = result_q;
        error_d      = error_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        ram_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    instr_d    = bus.instruction[LATCH_W-1:0];
                    finished_d = 1'b0;
                    error_d    = 1'b0;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_NOP, OP_MEMREAD, OP_MEMWRITE: ;
                    OP_DRAW: begin
                        vga_x_d      = w_x;
                        vga_y_d      = w_y;
                        vga_colour_d = w_colour;
                    end
                    default: begin
                        error_d  = 1'b1;
                        result_d = '1;
                    end
                endcase
            end
            S_MEM_RD: ;
            S_MEM_RD_DATA: begin
                result_d   = mem_rdata_q;
                finished_d = 1'b1;
            end
            S_MEM_WR: begin
                ram_we     = 1'b1;
                result_d   = w_data;
                finished_d = 1'b1;
            end
            S_DRAW: begin
                if (bus.vga_ready) vga_plot_d = w_plot_en;
            end
            S_DRAW_END: begin
                result_d   = '0;
                finished_d = 1'b1;
            end
            S_DONE: begin
                if (w_op == OP_NOP) result_d = '0;
                finished_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Single-port RAM with registered read; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (ram_we && !reset) mem_q[w_addr] <= w_data;
        mem_rdata_q <= mem_q[w_addr];
    end

    assign bus.finished   = finished_q;
    assign bus.result     = result_q;
    assign bus.error      = error_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule
`default_nettype wire

// File: tb/tb_datapath_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_responder
// Description : Directed plus randomized bench for datapath_responder against
//               a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_responder_if bus_if ();
    datapath_responder dut (.clock(clk), .reset(rst), .bus(bus_if));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: what the outputs must be after each edge.
    logic [15:0] m_mem [1024];
    bit          m_valid [1024];
    logic        m_fin, m_err, m_plot, m_prev_start, m_busy, m_drawn, m_res_known;
    logic [15:0] m_res;
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic [2:0]  m_c;
    logic [31:0] m_ins;
    int          m_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One edge of the model: m_k counts edges since the accepting edge.
    task automatic model_step();
        logic [9:0] a;
        if (rst) begin
            m_fin = 1; m_res = 0; m_res_known = 1; m_err = 0; m_plot = 0;
            m_x = 0; m_y = 0; m_c = 0; m_busy = 0; m_prev_start = 0;
        end else begin
            m_plot = 0;
            a = m_ins[12:3];
            if (!m_busy) begin
                if (bus_if.start && !m_prev_start) begin
                    m_busy = 1; m_k = 0; m_ins = bus_if.instruction;
                    m_fin = 0; m_err = 0; m_drawn = 0;
                end
            end else begin
                m_k++;
                case (m_ins[2:0])
                    3'd0: if (m_k == 2) begin m_res = 0; m_res_known = 1; m_fin = 1; m_busy = 0; end
                    3'd1: if (m_k == 3) begin
                        m_res = m_mem[a]; m_res_known = m_valid[a]; m_fin = 1; m_busy = 0;
                    end
                    3'd2: if (m_k == 2) begin
                        m_mem[a] = m_ins[28:13]; m_valid[a] = 1;
                        m_res = m_ins[28:13]; m_res_known = 1; m_fin = 1; m_busy = 0;
                    end
                    3'd3: begin
                        if (m_k == 1) begin
                            m_x = m_ins[10:3]; m_y = m_ins[17:11]; m_c = m_ins[20:18];
                        end else if (!m_drawn) begin
                            if (bus_if.vga_ready) begin m_plot = m_ins[21]; m_drawn = 1; end
                        end else begin
                            m_res = 0; m_res_known = 1; m_fin = 1; m_busy = 0;
                        end
                    end
                    default: begin
                        if (m_k == 1) begin m_err = 1; m_res = 16'hFFFF; m_res_known = 1; end
                        if (m_k == 2) begin m_fin = 1; m_busy = 0; end
                    end
                endcase
            end
            m_prev_start = bus_if.start;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("finished", bus_if.finished, m_fin);
                chk("error", bus_if.error, m_err);
                if (m_fin && m_res_known) chk("result", bus_if.result, m_res);
                chk("vga_plot", bus_if.vga_plot, m_plot);
                chk("vga_x", bus_if.vga_x, m_x);
                chk("vga_y", bus_if.vga_y, m_y);
                chk("vga_colour", bus_if.vga_colour, m_c);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (bus_if.finished !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) chk("idle_timeout", 0, 1);
    endtask

    // Issue one command: start high for 'hold' edges, vga_ready low until
    // edge E(2+rdly). Reports latency in edges from E0 plus any plot pulses.
    task automatic run_cmd(input logic [31:0] ins, input int hold, input int rdly,
                           output int lat, output logic fin1, output int pulses,
                           output logic [7:0] px, output logic [6:0] py, output logic [2:0] pc);
        int cyc;
        wait_idle();
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.instruction = ins; bus_if.vga_ready = 1'b0;
        cyc = -1; lat = 0; pulses = 0; fin1 = 1'b1; px = 0; py = 0; pc = 0;
        while ((lat == 0 || cyc < hold - 1) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) fin1 = bus_if.finished;
            if (bus_if.vga_plot) begin
                pulses++; px = bus_if.vga_x; py = bus_if.vga_y; pc = bus_if.vga_colour;
            end
            if (lat == 0 && cyc > 0 && bus_if.finished) lat = cyc;
            if (cyc + 1 >= hold) bus_if.start = 1'b0;
            bus_if.vga_ready = (cyc + 1 >= 2 + rdly);
        end
        bus_if.start = 1'b0;
        if (lat == 0) chk("cmd_timeout", 0, 1);
    endtask

    // Start a command, then reset on edge E(k+1).
    task automatic reset_mid(input logic [31:0] ins, input int k);
        wait_idle();
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.instruction = ins;
        for (int c = 0; c <= k; c++) begin @(posedge clk); #1; end
        rst = 1'b1; bus_if.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_finished", bus_if.finished, 1);
        chk("rst_mid_result", bus_if.result, 0);
        chk("rst_mid_plot", bus_if.vga_plot, 0);
    endtask

    function automatic logic [31:0] mk_wr(input logic [9:0] a, input logic [15:0] d);
        return {3'b000, d, a, 3'd2};
    endfunction
    function automatic logic [31:0] mk_rd(input logic [9:0] a);
        return {19'd0, a, 3'd1};
    endfunction
    function automatic logic [31:0] mk_draw(input logic [7:0] x, input logic [6:0] y,
                                            input logic [2:0] c, input logic p);
        return {10'd0, p, c, y, x, 3'd3};
    endfunction

    initial begin
        int lat, pulses, sel, k;
        logic fin1;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic [31:0] ins;
        logic [9:0] a;

        bus_if.start = 1'b0; bus_if.instruction = '0; bus_if.vga_ready = 1'b0;
        for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1'b1;
        chk("reset_finished", bus_if.finished, 1);
        chk("reset_result", bus_if.result, 0);
        chk("reset_error", bus_if.error, 0);
        chk("reset_plot", bus_if.vga_plot, 0);

        run_cmd(mk_wr(10'h000, 16'h0A0A), 2, 0, lat, fin1, pulses, px, py, pc);
        run_cmd(mk_wr(10'h005, 16'h1234), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("wr5_fin_e1", fin1, 0);
        chk("wr5_latency", lat, 2);
        chk("wr5_result", bus_if.result, 16'h1234);
        run_cmd(mk_rd(10'h005), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("rd5_latency", lat, 3);
        chk("rd5_result", bus_if.result, 16'h1234);

        run_cmd(mk_wr(10'h3FF, 16'hBEEF), 2, 0, lat, fin1, pulses, px, py, pc);
        run_cmd(mk_rd(10'h3FF), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("rd3ff_result", bus_if.result, 16'hBEEF);
        run_cmd(mk_rd(10'h000), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("rd0_result", bus_if.result, 16'h0A0A);

        run_cmd(mk_draw(8'd12, 7'd34, 3'd5, 1'b1), 2, 5, lat, fin1, pulses, px, py, pc);
        chk("draw_latency", lat, 8);
        chk("draw_pulses", pulses, 1);
        chk("draw_x", px, 12);
        chk("draw_y", py, 34);
        chk("draw_colour", pc, 5);
        chk("draw_result", bus_if.result, 0);
        run_cmd(mk_draw(8'd1, 7'd2, 3'd3, 1'b0), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("draw_noplot_pulses", pulses, 0);
        chk("draw_noplot_latency", lat, 3);

        run_cmd(mk_wr(10'h007, 16'h5555), 6, 0, lat, fin1, pulses, px, py, pc);
        chk("hold_latency", lat, 2);
        chk("hold_still_idle", bus_if.finished, 1);
        run_cmd(mk_rd(10'h007), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("hold_rd_result", bus_if.result, 16'h5555);

        run_cmd(32'h0000_0006, 2, 0, lat, fin1, pulses, px, py, pc);
        chk("illegal_latency", lat, 2);
        chk("illegal_error", bus_if.error, 1);
        chk("illegal_result", bus_if.result, 16'hFFFF);
        run_cmd(32'h0000_0000, 2, 0, lat, fin1, pulses, px, py, pc);
        chk("nop_latency", lat, 2);
        chk("nop_error", bus_if.error, 0);
        chk("nop_result", bus_if.result, 0);

        reset_mid(mk_rd(10'h005), 1);
        run_cmd(mk_rd(10'h005), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("after_rst_rd", bus_if.result, 16'h1234);
        reset_mid(mk_wr(10'h005, 16'h9999), 1);
        run_cmd(mk_rd(10'h005), 2, 0, lat, fin1, pulses, px, py, pc);
        chk("dropped_wr_rd", bus_if.result, 16'h1234);

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15))
                                            : 10'(10'h3F0 + $urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin ins[12:0] = {a, 3'd2}; end
                3, 4, 5: begin ins[12:0] = {a, 3'd1}; end
                6, 7:    begin ins[2:0] = 3'd3; end
                8:       begin ins[2:0] = 3'd0; end
                default: begin ins[2:0] = 3'($urandom_range(4, 7)); end
            endcase
            if ($urandom_range(0, 24) == 0) begin
                k = $urandom_range(0, 3);
                reset_mid(ins, k);
            end else begin
                run_cmd(ins, $urandom_range(2, 4), $urandom_range(0, 3),
                        lat, fin1, pulses, px, py, pc);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
